// File: rtl/osiris_wb_pkg.sv
// Shared Wishbone slave definitions: FSM state encoding and the width of the
// wait-state counter.
package osiris_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ACK  = 2'b10
    } wb_state_e;

    localparam int WAIT_CNT_WIDTH = 4;

endpackage

// File: rtl/osiris_sp_ram.sv
// Single-port word memory with a synchronous write and an asynchronous read.
// The contents are never cleared by reset.
module osiris_sp_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic RAM slave with a programmable number of wait states.
// Define WB_RAM_ERR_EN to add wb_err_o, raised instead of ack for out-of-range accesses.
module wb_ram_slave
    import osiris_wb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_we_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o
`ifdef WB_RAM_ERR_EN
    ,
    output logic                  wb_err_o
`endif
);

    wb_state_e                 state;
    wb_state_e                 state_next;
    logic [WAIT_CNT_WIDTH-1:0] cnt;
    logic [WAIT_CNT_WIDTH-1:0] cnt_next;

    logic                  req;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  we_q;
    logic                  in_range_q;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign req      = wb_cyc_i && wb_stb_i;
    assign in_range = ((wb_adr_i >> (DEPTH_LOG2 + 2)) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ACK;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_CNT_WIDTH'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                // Dropping cyc abandons the transfer before anything is committed.
                if (!wb_cyc_i) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    state_next = ACK;
                end else begin
                    cnt_next = cnt - WAIT_CNT_WIDTH'(1);
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q      <= '0;
            dat_q      <= '0;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
        end else if (state == IDLE && req) begin
            idx_q      <= wb_adr_i[DEPTH_LOG2+1:2];
            dat_q      <= wb_dat_i;
            we_q       <= wb_we_i;
            in_range_q <= in_range;
        end
    end

    // The write lands on the same edge that raises the acknowledge.
    assign ram_we = (state == ACK) && we_q && in_range_q;

    osiris_sp_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (idx_q),
        .wdata (dat_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
`ifdef WB_RAM_ERR_EN
            wb_err_o <= 1'b0;
`endif
        end else begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
`ifdef WB_RAM_ERR_EN
            wb_err_o <= 1'b0;
`endif
            if (state == ACK) begin
`ifdef WB_RAM_ERR_EN
                wb_ack_o <= in_range_q;
                wb_err_o <= !in_range_q;
`else
                wb_ack_o <= 1'b1;
`endif
                if (!we_q && in_range_q) begin
                    wb_dat_o <= ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Scoreboard bench for wb_ram_slave: three instances with 1, 0 and 3 wait states.
// Expected responses are queued by the stimulus and checked by a negedge monitor.
module tb_wb_ram_slave;

`ifdef WB_RAM_ERR_EN
    localparam bit ERR_BUILD = 1'b1;
`else
    localparam bit ERR_BUILD = 1'b0;
`endif

    typedef struct {
        int          dut;
        logic [31:0] dat;
        logic        chk;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sbq[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] adr  [3];
    logic [31:0] wdat [3];
    logic [31:0] rdat [3];
    logic        we   [3];
    logic        stb  [3];
    logic        cyc  [3];
    logic        ack  [3];
    logic        err  [3];

    int cyc_n  = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    function automatic int ws_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    wb_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(1)) dut_ws1 (
        .clk(clk), .rst(rst), .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_we_i(we[0]),
        .wb_stb_i(stb[0]), .wb_cyc_i(cyc[0]), .wb_dat_o(rdat[0]), .wb_ack_o(ack[0])
`ifdef WB_RAM_ERR_EN
        , .wb_err_o(err[0])
`endif
    );

    wb_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst(rst), .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_we_i(we[1]),
        .wb_stb_i(stb[1]), .wb_cyc_i(cyc[1]), .wb_dat_o(rdat[1]), .wb_ack_o(ack[1])
`ifdef WB_RAM_ERR_EN
        , .wb_err_o(err[1])
`endif
    );

    wb_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(3)) dut_ws3 (
        .clk(clk), .rst(rst), .wb_adr_i(adr[2]), .wb_dat_i(wdat[2]), .wb_we_i(we[2]),
        .wb_stb_i(stb[2]), .wb_cyc_i(cyc[2]), .wb_dat_o(rdat[2]), .wb_ack_o(ack[2])
`ifdef WB_RAM_ERR_EN
        , .wb_err_o(err[2])
`endif
    );

`ifndef WB_RAM_ERR_EN
    assign err[0] = 1'b0;
    assign err[1] = 1'b0;
    assign err[2] = 1'b0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge. With hold set the request
    // stays asserted through the ack cycle so the next call chains back-to-back.
    task automatic applyStimulus(input int d, input logic [31:0] a, input logic [31:0] wd,
                                 input logic w, input logic [31:0] exp_dat,
                                 input logic exp_err, input bit hold);
        exp_t e;
        adr[d]  = a;
        wdat[d] = wd;
        we[d]   = w;
        stb[d]  = 1'b1;
        cyc[d]  = 1'b1;
        e.dut = d;
        e.dat = exp_dat;
        e.chk = !w;
        e.err = exp_err;
        e.cyc = cyc_n + ws_of(d) + 2;
        sbq.push_back(e);
        repeat (ws_of(d) + 2) @(negedge clk);
        if (!hold) begin
            stb[d] = 1'b0;
            cyc[d] = 1'b0;
            we[d]  = 1'b0;
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ack[d] || err[d]) begin
                if (sbq.size() == 0 || sbq[0].dut != d) begin
                    errors++;
                    $display("[TB] FAIL unexpected_resp dut%0d cyc=%0d: got ack=%b err=%b dat=%h, required no response",
                             d, cyc_n, ack[d], err[d], rdat[d]);
                end else begin
                    e = sbq.pop_front();
                    if (ack[d] !== !e.err || err[d] !== e.err || cyc_n != e.cyc ||
                        (e.chk && rdat[d] !== e.dat)) begin
                        errors++;
                        $display("[TB] FAIL resp dut%0d: got ack=%b err=%b dat=%h cyc=%0d, required ack=%b err=%b dat=%h cyc=%0d",
                                 d, ack[d], err[d], rdat[d], cyc_n, !e.err, e.err, e.dat, e.cyc);
                    end
                end
            end else if (rdat[d] !== 32'h0) begin
                errors++;
                $display("[TB] FAIL idle_dat dut%0d cyc=%0d: got %h, required 00000000", d, cyc_n, rdat[d]);
            end
        end
        if (sbq.size() > 0 && cyc_n > sbq[0].cyc) begin
            checks++;
            errors++;
            e = sbq.pop_front();
            $display("[TB] FAIL missing_resp dut%0d: got nothing by cyc=%0d, required response at cyc=%0d",
                     e.dut, cyc_n, e.cyc);
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            adr[d] = '0; wdat[d] = '0; we[d] = 1'b0; stb[d] = 1'b0; cyc[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("reset_ack%0d", d), 32'(ack[d]), 32'h0);
            checkOutput($sformatf("reset_dat%0d", d), rdat[d], 32'h0);
`ifdef WB_RAM_ERR_EN
            checkOutput($sformatf("reset_err%0d", d), 32'(err[d]), 32'h0);
`endif
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 0x2000_0004 has upper address bits set, so it lies outside the array and is dropped.
        applyStimulus(0, 32'h0000_0004, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 1'b0);
        applyStimulus(0, 32'h2000_0004, 32'hDEAD_BEEF, 1'b1, 32'h0, ERR_BUILD, 1'b0);
        applyStimulus(0, 32'h0000_0004, 32'h0, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
        applyStimulus(0, 32'h0000_0004, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 1'b0);
        applyStimulus(0, 32'h0000_0004, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        applyStimulus(0, 32'h0000_0000, 32'hA5A5_A5A5, 1'b1, 32'h0, 1'b0, 1'b0);
        applyStimulus(0, 32'h0000_1000, 32'h0, 1'b0, 32'h0, ERR_BUILD, 1'b0);
        applyStimulus(0, 32'h0000_0008, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0, 1'b0);
        applyStimulus(0, 32'h0000_000B, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);

        applyStimulus(1, 32'h0000_0000, 32'h0BAD_0000, 1'b1, 32'h0, 1'b0, 1'b1);
        applyStimulus(1, 32'h0000_0004, 32'h0BAD_0004, 1'b1, 32'h0, 1'b0, 1'b1);
        applyStimulus(1, 32'h0000_0000, 32'h0, 1'b0, 32'h0BAD_0000, 1'b0, 1'b1);
        applyStimulus(1, 32'h0000_0004, 32'h0, 1'b0, 32'h0BAD_0004, 1'b0, 1'b0);

        applyStimulus(2, 32'h0000_0010, 32'h1111_1111, 1'b1, 32'h0, 1'b0, 1'b0);
        adr[2] = 32'h0000_0010; wdat[2] = 32'h2222_2222; we[2] = 1'b1; stb[2] = 1'b1; cyc[2] = 1'b1;
        @(negedge clk);
        cyc[2] = 1'b0;
        @(negedge clk);
        stb[2] = 1'b0; we[2] = 1'b0;
        repeat (6) @(negedge clk);
        applyStimulus(2, 32'h0000_0010, 32'h0, 1'b0, 32'h1111_1111, 1'b0, 1'b0);

        applyStimulus(2, 32'h0000_0014, 32'h3333_3333, 1'b1, 32'h0, 1'b0, 1'b0);
        adr[2] = 32'h0000_0014; wdat[2] = 32'h4444_4444; we[2] = 1'b1; stb[2] = 1'b1; cyc[2] = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_wait_ack", 32'(ack[2]), 32'h0);
        checkOutput("rst_wait_dat", rdat[2], 32'h0);
        stb[2] = 1'b0; cyc[2] = 1'b0; we[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(2, 32'h0000_0014, 32'h0, 1'b0, 32'h3333_3333, 1'b0, 1'b0);

        applyStimulus(1, 32'h0000_0020, 32'h5555_5555, 1'b1, 32'h0, 1'b0, 1'b0);
        adr[1] = 32'h0000_0020; we[1] = 1'b0; stb[1] = 1'b1; cyc[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_ack", 32'(ack[1]), 32'h1);
        checkOutput("pre_rst_dat", rdat[1], 32'h5555_5555);
        rst = 1'b0;
        #1;
        checkOutput("rst_ack_ack", 32'(ack[1]), 32'h0);
        checkOutput("rst_ack_dat", rdat[1], 32'h0);
        stb[1] = 1'b0; cyc[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1, 32'h0000_0020, 32'h0, 1'b0, 32'h5555_5555, 1'b0, 1'b0);
        applyStimulus(0, 32'h0000_0008, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_resp: got %0d outstanding, required 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
